// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, multi-cycle MUL freeze, taken-branch flush.
// Optional performance counters are enabled with the macro PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rn,
    input  logic             id_uses_rm,
    input  logic             id_is_mul,
    input  logic             id_br_taken,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_stall,
    output logic             exmem_bubble,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    if ((MUL_LAT < 2) || (MUL_LAT > 16)) begin : g_bad_mul_lat
        $error("pipe_hazard_ctrl: MUL_LAT must lie in 2..16");
    end

    localparam logic [3:0] LP_CNT_INIT = 4'(MUL_LAT - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_mul_cnt;
    logic [3:0] w_mul_cnt_nxt;
    logic       w_lu;

    // XZR is hard-wired zero, so a load targeting it never creates a dependency.
    assign w_lu = ex_mem_read && (ex_rd != 5'd31) &&
                  ((id_uses_rn && (id_rn == ex_rd)) || (id_uses_rm && (id_rm == ex_rd)));

    // State and MUL iteration counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= RUN;
            r_mul_cnt <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_mul_cnt <= w_mul_cnt_nxt;
        end
    end

    // Next-state and pipeline control; MUL_WAIT outranks load-use, which outranks the flush.
    always_comb begin
        w_state_nxt   = r_state;
        w_mul_cnt_nxt = r_mul_cnt;
        pc_stall      = 1'b0;
        ifid_stall    = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        idex_stall    = 1'b0;
        exmem_bubble  = 1'b0;
        mul_busy      = 1'b0;
        if (!reset_n) begin
            w_state_nxt   = RUN;
            w_mul_cnt_nxt = 4'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_lu) begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (id_br_taken) begin
                        ifid_flush = 1'b1;
                    end else if (id_is_mul) begin
                        w_state_nxt   = MUL_WAIT;
                        w_mul_cnt_nxt = LP_CNT_INIT;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
                MUL_WAIT: begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_stall = 1'b1;
                    mul_busy   = 1'b1;
                    // Final iteration lets the product fall through into EX/MEM.
                    if (r_mul_cnt == 4'd1) begin
                        exmem_bubble  = 1'b0;
                        w_state_nxt   = RUN;
                        w_mul_cnt_nxt = 4'd0;
                    end else begin
                        exmem_bubble  = 1'b1;
                        w_mul_cnt_nxt = r_mul_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt   = RUN;
                    w_mul_cnt_nxt = 4'd0;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    // Saturating stall and flush counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (pc_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (ifid_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = reset_n ? r_stall_cycles : '0;
    assign flush_count  = reset_n ? r_flush_count  : '0;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [4:0]       id_rn, id_rm, ex_rd;
    logic             id_uses_rn, id_uses_rm, id_is_mul, id_br_taken, ex_mem_read;
    logic             pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_bubble, mul_busy;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
        .id_is_mul(id_is_mul), .id_br_taken(id_br_taken), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_stall(idex_stall), .exmem_bubble(exmem_bubble),
        .mul_busy(mul_busy), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               cyc;
        logic [6:0]       flags;   // pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_bubble, mul_busy
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: cycles of MUL freeze still to go, plus event totals.
    int     m_mul_left = 0;
    longint m_stalls   = 0;
    longint m_flushes  = 0;

    task automatic step(input bit rst, input bit [4:0] rn, input bit [4:0] rm, input bit urn,
                        input bit urm, input bit mul, input bit br, input bit [4:0] rd, input bit mr);
        exp_t e;
        bit   ps, is, fl, ib, xs, eb, mb, lu;
        @(posedge clk);
        #1;
        reset_n = ~rst; id_rn = rn; id_rm = rm; id_uses_rn = urn; id_uses_rm = urm;
        id_is_mul = mul; id_br_taken = br; ex_rd = rd; ex_mem_read = mr;
        {ps, is, fl, ib, xs, eb, mb} = 7'd0;
        e.cyc = cyc;
        e.sc  = '0;
        e.fc  = '0;
        if (rst) begin
            m_mul_left = 0; m_stalls = 0; m_flushes = 0;
        end else begin
`ifdef PIPE_HAZARD_PERF_EN
            e.sc = CNT_W'(m_stalls);
            e.fc = CNT_W'(m_flushes);
`endif
            if (m_mul_left > 0) begin
                ps = 1'b1; is = 1'b1; xs = 1'b1; mb = 1'b1;
                eb = (m_mul_left > 1);
                m_mul_left--;
            end else begin
                lu = mr && (rd != 5'd31) && ((urn && rn == rd) || (urm && rm == rd));
                if (lu) begin
                    ps = 1'b1; is = 1'b1; ib = 1'b1;
                end else if (br) begin
                    fl = 1'b1;
                end else if (mul) begin
                    m_mul_left = MUL_LAT - 1;
                end
            end
            if (ps) m_stalls++;
            if (fl) m_flushes++;
        end
        e.flags = {ps, is, fl, ib, xs, eb, mb};
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Monitor: the outputs are combinational, so each cycle is checked at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [6:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_bubble, mul_busy};
            checks += 3;
            if (act !== e.flags) begin
                errors++;
                $display("FAIL ctrl cyc=%0d got=%b want=%b", e.cyc, act, e.flags);
            end
            if (stall_cycles !== e.sc) begin
                errors++;
                $display("FAIL stall_cycles cyc=%0d got=%0d want=%0d", e.cyc, stall_cycles, e.sc);
            end
            if (flush_count !== e.fc) begin
                errors++;
                $display("FAIL flush_count cyc=%0d got=%0d want=%0d", e.cyc, flush_count, e.fc);
            end
        end
    end

    initial begin
        logic [CNT_W-1:0] want_sc, want_fc;
        int kind;
        reset_n = 1'b0; id_rn = 5'd0; id_rm = 5'd0; id_uses_rn = 1'b0; id_uses_rm = 1'b0;
        id_is_mul = 1'b0; id_br_taken = 1'b0; ex_rd = 5'd0; ex_mem_read = 1'b0;

        // Counter scenario: one load-use, one MUL, one flush.
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step(1'b0, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
        idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        repeat (3) idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
        idle();
        @(negedge clk);
        #1;
`ifdef PIPE_HAZARD_PERF_EN
        want_sc = CNT_W'(4);
        want_fc = CNT_W'(1);
`else
        want_sc = '0;
        want_fc = '0;
`endif
        checks += 2;
        if (stall_cycles !== want_sc) begin
            errors++;
            $display("FAIL perf_stall got=%0d want=%0d", stall_cycles, want_sc);
        end
        if (flush_count !== want_fc) begin
            errors++;
            $display("FAIL perf_flush got=%0d want=%0d", flush_count, want_fc);
        end

        // XZR exemption, then branch against load-use, back-to-back MULs, reset mid-MUL.
        step(1'b0, 5'd31, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1);
        step(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
        step(1'b0, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
        repeat (MUL_LAT + 2) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        idle(); idle(); idle();
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        idle();
        step(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 1'b1);
        idle(); idle();

        // Random traffic on a small register range so hazards are frequent.
        for (int i = 0; i < 2000; i++) begin
            kind = int'($urandom_range(0, 9));
            step(($urandom_range(0, 99) == 0), 5'($urandom_range(28, 31)), 5'($urandom_range(28, 31)),
                 1'($urandom), 1'($urandom), (kind == 0), (kind == 1 || kind == 2),
                 5'($urandom_range(28, 31)), 1'($urandom));
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Stall/flush controller for the 5-stage ARM pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards between ID and EX and inserts a one-cycle bubble.
- Sequences the multi-cycle MUL unit by freezing the front end while EX iterates.
- Flushes IF/ID on a taken branch resolved in ID.
- Sits beside the decode control block; drives the pipeline-register enables and bubble selects.

Parameters:
MUL_LAT, 4, total EX-stage cycles a MUL occupies (legal range 2..16).
CNT_W, 32, width of performance counters (used only with the optional feature).

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset
id_rn  input  5  Rn field of the instruction in ID
id_rm  input  5  second source register of the ID instruction, already Reg2Loc-muxed
id_uses_rn  input  1  ID instruction reads Rn
id_uses_rm  input  1  ID instruction reads the second source
id_is_mul  input  1  ID instruction is MUL
id_br_taken  input  1  branch in ID resolved taken (BrTaken)
ex_rd  input  5  destination register of the EX instruction
ex_mem_read  input  1  EX instruction is LDUR
pc_stall  output  1  hold PC
ifid_stall  output  1  hold IF/ID register
ifid_flush  output  1  load NOP into IF/ID
idex_bubble  output  1  load NOP (all control 0) into ID/EX
idex_stall  output  1  hold ID/EX register
exmem_bubble  output  1  load NOP into EX/MEM
mul_busy  output  1  MUL iteration in progress
stall_cycles  output  CNT_W  stalled-cycle count (optional feature)
flush_count  output  CNT_W  IF/ID flush count (optional feature)

Behaviour:
- State machine: RUN, MUL_WAIT. State and counter are registers.
- mul_cnt is a 4-bit down-counter.
- All outputs are combinational from state, mul_cnt and inputs, and are forced to 0 while reset_n=0.
- Reset (reset_n=0 at a rising edge): state=RUN, mul_cnt=0, counters=0.
- Load-use hazard, evaluated in RUN only, as lu:
  - lu = ex_mem_read & ex_rd!=31 & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd)).
  - X31 (XZR) never creates a hazard.
- RUN outputs:
  - lu=1: pc_stall=ifid_stall=idex_bubble=1; ifid_flush=0; id_br_taken and id_is_mul are ignored this cycle. The stall lasts exactly one cycle, because the bubble removes the load from EX.
  - lu=0 and id_br_taken=1: ifid_flush=1, all others 0.
  - lu=0 and id_is_mul=1: no stall this cycle; the MUL advances into EX. Next state=MUL_WAIT, mul_cnt=MUL_LAT-1.
  - id_br_taken and id_is_mul never occur together (a single instruction).
- MUL_WAIT outputs:
  - pc_stall=ifid_stall=idex_stall=1 and exmem_bubble=1; mul_busy=1; ifid_flush=0.
  - id_br_taken, id_is_mul and lu are all ignored.
- MUL_WAIT counting:
  - mul_cnt decrements each cycle.
  - When mul_cnt==1, exmem_bubble=0 so the MUL result is captured into EX/MEM; next state=RUN, mul_cnt=0.
  - Net: a MUL occupies EX for exactly MUL_LAT cycles and inserts MUL_LAT-1 stall cycles.
- Back-to-back MULs: the second MUL waits in ID during MUL_WAIT. On return to RUN it issues and re-enters MUL_WAIT on the following edge; there is no idle gap.
- Priority, high to low: reset, MUL_WAIT, load-use, branch flush.
- Reset mid-MUL: returns to RUN immediately; mul_busy=0 in the first cycle after reset deasserts.
- MUL_LAT outside 2..16: elaboration error.

Optional Feature:
Macro PIPE_HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle where pc_stall=1.
  - flush_count increments on every cycle where ifid_flush=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports are present and driven constant 0; no counter flops are instantiated.

Test Plan:
- Load-use on Rn: LDUR X2 in EX (ex_mem_read=1, ex_rd=2), ID ADDS uses_rn=1, id_rn=2 -> pc_stall=ifid_stall=idex_bubble=1 for exactly 1 cycle, then all 0.
- XZR exemption: ex_mem_read=1, ex_rd=31, id_rn=31, id_uses_rn=1 -> no stall.
- MUL with MUL_LAT=4: id_is_mul pulsed at cycle 0 -> mul_busy=1 on cycles 1-3; exmem_bubble=1 on cycles 1-2 and 0 on cycle 3; state RUN at cycle 4; 3 stalled cycles.
- Branch flush vs load-use: id_br_taken=1 with lu=1 -> ifid_flush=0 and stall=1. Next cycle, lu=0 and id_br_taken=1 -> ifid_flush=1 and no stall.
- Reset mid-MUL: reset_n=0 at cycle 2 of MUL_WAIT -> all outputs 0 that cycle; after release, state RUN and mul_busy=0.
- With PIPE_HAZARD_PERF_EN: one load-use stall, one MUL (MUL_LAT=4) and one flush -> stall_cycles=4, flush_count=1. Without the macro, both read 0.
